// File: rtl/camera_capture_window.sv
// camera_capture_window: pairs OV7670 bytes into RGB565 pixels, crops/decimates them and issues linear frame-buffer writes
// Optional feature macro CAPTURE_TESTPAT_EN: adds input test_mode, replacing camera pixels with a col/row pattern while ACTIVE.
module camera_capture_window #(
  parameter int H_ACTIVE   = 640,
  parameter int WIN_X0     = 0,
  parameter int WIN_Y0     = 0,
  parameter int WIN_W      = 640,
  parameter int WIN_H      = 480,
  parameter int DECIM_LOG2 = 0,
  parameter int R_BITS     = 4,
  parameter int G_BITS     = 4,
  parameter int B_BITS     = 4,
  parameter int ADDR_W     = 19,
  localparam int PIX_W     = R_BITS + G_BITS + B_BITS
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              href,
  input  logic              vsyn,
  input  logic [7:0]        camera_data,
  input  logic              capture_en,
`ifdef CAPTURE_TESTPAT_EN
  input  logic              test_mode,
`endif
  output logic              wren,
  output logic [PIX_W-1:0]  camera_color_write,
  output logic [ADDR_W-1:0] store_addr,
  output logic              busy,
  output logic              frame_done,
  output logic              line_err,
  output logic              addr_ovf
);
  localparam logic [1:0] S_WAIT   = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_SKIP   = 2'd3;
  localparam int CW = 16;
  localparam logic [CW-1:0] X0    = CW'(WIN_X0);
  localparam logic [CW-1:0] Y0    = CW'(WIN_Y0);
  localparam logic [CW-1:0] WW    = CW'(WIN_W);
  localparam logic [CW-1:0] WH    = CW'(WIN_H);
  localparam logic [CW-1:0] H_LEN = CW'(H_ACTIVE);
  localparam logic [CW-1:0] DMASK = CW'((1 << DECIM_LOG2) - 1);
  localparam longint NPIX = longint'(WIN_W >> DECIM_LOG2) * longint'(WIN_H >> DECIM_LOG2);
  localparam longint NCAP = longint'(1) << ADDR_W;
  // Last writable address: the window size, clipped to what the address bus can reach
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'((NPIX < NCAP ? NPIX : NCAP) - 1);

  logic [1:0]        state_q, state_d;
  logic              phase_q, phase_d;
  logic              href_q, href_d;
  logic [7:0]        hi_q, hi_d;
  logic [CW-1:0]     col_q, col_d;
  logic [CW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] next_q, next_d;
  logic [ADDR_W-1:0] store_addr_q, store_addr_d;
  logic              full_q, full_d;
  logic              wren_q, wren_d;
  logic [PIX_W-1:0]  color_q, color_d;
  logic              frame_done_q, frame_done_d;
  logic              line_err_q, line_err_d;
  logic              addr_ovf_q, addr_ovf_d;
  logic [15:0]       pix;
  logic              active, counting, pix_done, href_fall, start, in_win, write_ok;
  logic [CW-1:0]     dx, dy;
  logic              unused_pix;

  // Pixel source: camera byte pair, or the col/row test pattern when enabled
  always_comb begin
`ifdef CAPTURE_TESTPAT_EN
    pix = (test_mode && state_q == S_ACTIVE) ? {col_q[7:3], row_q[5:0], col_q[4:0]} : {hi_q, camera_data};
`else
    pix = {hi_q, camera_data};
`endif
    unused_pix = ^pix;
  end

  // Frame sequencing, byte pairing, windowing, address generation and flags
  always_comb begin
    active    = state_q == S_ACTIVE;
    counting  = state_q == S_ACTIVE || state_q == S_SKIP;
    pix_done  = href && phase_q;
    href_fall = href_q && !href;
    start     = state_q == S_IDLE && vsyn && capture_en;
    dx        = col_q - X0;
    dy        = row_q - Y0;
    in_win    = dx < WW && dy < WH && (dx & DMASK) == '0 && (dy & DMASK) == '0;
    write_ok  = active && pix_done && in_win;
    case (state_q)
      S_WAIT:  state_d = vsyn ? S_WAIT : S_IDLE;
      S_IDLE:  state_d = vsyn ? (capture_en ? S_ACTIVE : S_SKIP) : S_IDLE;
      default: state_d = vsyn ? state_q : S_IDLE;
    endcase
    href_d       = href;
    phase_d      = href && !phase_q;
    hi_d         = (href && !phase_q) ? camera_data : hi_q;
    col_d        = (!counting || href_fall) ? '0 : col_q + CW'(pix_done);
    row_d        = !counting ? '0 : row_q + CW'(href_fall);
    wren_d       = write_ok && !full_q;
    store_addr_d = !counting ? '0 : wren_d ? next_q : store_addr_q;
    next_d       = !counting ? '0 : (wren_d && next_q != LAST) ? next_q + ADDR_W'(1) : next_q;
    full_d       = counting && (full_q || (wren_d && next_q == LAST));
    color_d      = wren_d ? {pix[15 -: R_BITS], pix[10 -: G_BITS], pix[4 -: B_BITS]} : color_q;
    frame_done_d = active && !vsyn;
    line_err_d   = !start && (line_err_q || (active && href_fall && (phase_q || col_q != H_LEN)));
    addr_ovf_d   = !start && (addr_ovf_q || (write_ok && full_q));
  end

  // State and output registers; reset abandons any frame in progress
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_WAIT;
      phase_q      <= 1'b0;
      href_q       <= 1'b0;
      hi_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      next_q       <= '0;
      store_addr_q <= '0;
      full_q       <= 1'b0;
      wren_q       <= 1'b0;
      color_q      <= '0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      addr_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      href_q       <= href_d;
      hi_q         <= hi_d;
      col_q        <= col_d;
      row_q        <= row_d;
      next_q       <= next_d;
      store_addr_q <= store_addr_d;
      full_q       <= full_d;
      wren_q       <= wren_d;
      color_q      <= color_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
      addr_ovf_q   <= addr_ovf_d;
    end
  end

  assign wren               = wren_q;
  assign camera_color_write = color_q;
  assign store_addr         = store_addr_q;
  assign busy               = state_q == S_ACTIVE;
  assign frame_done         = frame_done_q;
  assign line_err           = line_err_q;
  assign addr_ovf           = addr_ovf_q;
endmodule

// File: tb/tb_camera_capture_window.sv
// tb_camera_capture_window: scoreboard bench driving four differently parameterised capturers from one camera stream
module tb_camera_capture_window;
  logic       pclk = 1'b0;
  logic       rst = 1'b0;
  logic       href = 1'b0;
  logic       vsyn = 1'b0;
  logic [7:0] camera_data = 8'h00;
  logic [3:0] cap_en = 4'h0;
  wire  [3:0] wren_v, busy_v, fd_v, le_v, ov_v;
  wire  [11:0] col_v [4];
  wire  [18:0] addr_v [4];
  wire  [1:0] addr3;

  assign addr_v[3] = {17'd0, addr3};

  always #5 pclk = ~pclk;

  camera_capture_window u0 (
    .pclk(pclk), .rst(rst), .href(href), .vsyn(vsyn), .camera_data(camera_data), .capture_en(cap_en[0]),
`ifdef CAPTURE_TESTPAT_EN
    .test_mode(1'b0),
`endif
    .wren(wren_v[0]), .camera_color_write(col_v[0]), .store_addr(addr_v[0]), .busy(busy_v[0]),
    .frame_done(fd_v[0]), .line_err(le_v[0]), .addr_ovf(ov_v[0]));

  camera_capture_window #(.H_ACTIVE(8), .WIN_X0(2), .WIN_W(4), .WIN_Y0(1), .WIN_H(2), .DECIM_LOG2(1)) u1 (
    .pclk(pclk), .rst(rst), .href(href), .vsyn(vsyn), .camera_data(camera_data), .capture_en(cap_en[1]),
`ifdef CAPTURE_TESTPAT_EN
    .test_mode(1'b0),
`endif
    .wren(wren_v[1]), .camera_color_write(col_v[1]), .store_addr(addr_v[1]), .busy(busy_v[1]),
    .frame_done(fd_v[1]), .line_err(le_v[1]), .addr_ovf(ov_v[1]));

  camera_capture_window #(.WIN_W(4), .WIN_H(1)) u2 (
    .pclk(pclk), .rst(rst), .href(href), .vsyn(vsyn), .camera_data(camera_data), .capture_en(cap_en[2]),
`ifdef CAPTURE_TESTPAT_EN
    .test_mode(1'b0),
`endif
    .wren(wren_v[2]), .camera_color_write(col_v[2]), .store_addr(addr_v[2]), .busy(busy_v[2]),
    .frame_done(fd_v[2]), .line_err(le_v[2]), .addr_ovf(ov_v[2]));

  camera_capture_window #(.WIN_W(8), .WIN_H(1), .ADDR_W(2)) u3 (
    .pclk(pclk), .rst(rst), .href(href), .vsyn(vsyn), .camera_data(camera_data), .capture_en(cap_en[3]),
`ifdef CAPTURE_TESTPAT_EN
    .test_mode(1'b0),
`endif
    .wren(wren_v[3]), .camera_color_write(col_v[3]), .store_addr(addr3), .busy(busy_v[3]),
    .frame_done(fd_v[3]), .line_err(le_v[3]), .addr_ovf(ov_v[3]));

  typedef struct packed {
    logic [1:0]  id;
    logic [18:0] addr;
    logic [11:0] col;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         fd_cnt [4] = '{0, 0, 0, 0};
  logic [3:0] prev_wren = 4'h0;

  // Monitor: every write from any instance must match the head of the expected queue
  always @(negedge pclk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (fd_v[i]) fd_cnt[i]++;
      if (wren_v[i]) begin
        checks++;
        if (prev_wren[i]) begin
          errors++;
          $display("FAIL wren_gap dut%0d: wren high on two consecutive cycles, required a gap", i);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write dut%0d: got unexpected write addr=%0d color=%03h, required no write", i, addr_v[i], col_v[i]);
        end else begin
          e = exp_q.pop_front();
          if (e.id != 2'(i) || e.addr != addr_v[i] || e.col != col_v[i]) begin
            errors++;
            $display("FAIL write: got dut%0d addr=%0d color=%03h, required dut%0d addr=%0d color=%03h",
                     i, addr_v[i], col_v[i], e.id, e.addr, e.col);
          end
        end
      end
    end
    prev_wren = wren_v;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic push(int id, int addr, int col);
    exp_q.push_back({2'(id), 19'(addr), 12'(col)});
  endtask

  task automatic frame_begin(logic [3:0] en);
    cap_en = en;
    vsyn = 1'b1;
    cyc(2);
  endtask

  task automatic frame_end();
    vsyn = 1'b0;
    cyc(3);
  endtask

  // mode 0: F8/1F, mode 1: 12/34, mode 2: {col[3:0],row[3:0]}/00
  task automatic send_line(int n, int mode, int row, bit dangle);
    for (int c = 0; c < n; c++) begin
      logic [7:0] h, l;
      h = mode == 0 ? 8'hF8 : mode == 1 ? 8'h12 : {4'(c), 4'(row)};
      l = mode == 0 ? 8'h1F : mode == 1 ? 8'h34 : 8'h00;
      href = 1'b1;
      camera_data = h;
      cyc();
      camera_data = l;
      cyc();
    end
    if (dangle) begin
      camera_data = 8'hF8;
      cyc();
    end
    href = 1'b0;
    camera_data = 8'h00;
    cyc(3);
  endtask

  task automatic drain(string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      cyc();
      t++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    cyc(2);
    chk("rst_wren", wren_v[0], 0);
    chk("rst_color", col_v[0], 0);
    chk("rst_addr", addr_v[0], 0);
    chk("rst_busy", busy_v[0], 0);
    chk("rst_frame_done", fd_v[0], 0);
    chk("rst_line_err", le_v[0], 0);
    chk("rst_addr_ovf", ov_v[0], 0);
    rst = 1'b1;
    cyc(3);

    // Full-width capture: 2 lines x 640 of F8/1F -> color F0F, addresses 0..1279
    for (int k = 0; k < 1280; k++) push(0, k, 'hF0F);
    frame_begin(4'b0001);
    chk("t1_busy", busy_v[0], 1);
    send_line(640, 0, 0, 1'b0);
    send_line(640, 0, 1, 1'b0);
    frame_end();
    drain("t1_drain");
    chk("t1_frame_done", fd_cnt[0], 1);
    chk("t1_busy_after", busy_v[0], 0);
    chk("t1_line_err", le_v[0], 0);

    // Cropped, decimated window: only (2,1) and (4,1) are written
    push(1, 0, 'h220);
    push(1, 1, 'h420);
    frame_begin(4'b0010);
    for (int r = 0; r < 4; r++) send_line(8, 2, r, 1'b0);
    frame_end();
    drain("t2_drain");
    chk("t2_frame_done", fd_cnt[1], 1);
    chk("t2_line_err", le_v[1], 0);
    chk("t2_addr_ovf", ov_v[1], 0);
    chk("t2_u0_frame_done", fd_cnt[0], 1);

    // Unarmed frame: no writes, not busy, no frame_done; then an armed frame restarts at 0
    frame_begin(4'b0000);
    chk("t3_busy_skip", busy_v[0], 0);
    send_line(640, 0, 0, 1'b0);
    send_line(640, 0, 1, 1'b0);
    frame_end();
    chk("t3_no_frame_done", fd_cnt[0], 1);
    for (int k = 0; k < 640; k++) push(0, k, 'h14A);
    frame_begin(4'b0001);
    send_line(640, 1, 0, 1'b0);
    frame_end();
    drain("t3_drain");
    chk("t3_frame_done", fd_cnt[0], 2);

    // Short line with dangling byte: line_err held through IDLE and skipped frames
    for (int k = 0; k < 639; k++) push(0, k, 'hF0F);
    frame_begin(4'b0001);
    chk("t4_line_err_start", le_v[0], 0);
    send_line(639, 0, 0, 1'b1);
    chk("t4_line_err_set", le_v[0], 1);
    frame_end();
    drain("t4_drain");
    chk("t4_frame_done", fd_cnt[0], 3);
    chk("t4_line_err_idle", le_v[0], 1);
    frame_begin(4'b0000);
    frame_end();
    chk("t4_line_err_skip", le_v[0], 1);
    frame_begin(4'b0001);
    chk("t4_line_err_cleared", le_v[0], 0);
    frame_end();
    chk("t4_frame_done_empty", fd_cnt[0], 4);

    // Address limit: 4-pixel window fits exactly; 8-pixel window on a 2-bit bus overflows
    for (int a = 0; a < 4; a++) push(2, a, a << 8);
    frame_begin(4'b0100);
    send_line(640, 2, 0, 1'b0);
    frame_end();
    drain("t5_fit_drain");
    chk("t5_fit_addr_ovf", ov_v[2], 0);
    chk("t5_fit_line_err", le_v[2], 0);
    chk("t5_fit_frame_done", fd_cnt[2], 1);
    for (int a = 0; a < 4; a++) push(3, a, a << 8);
    frame_begin(4'b1000);
    send_line(640, 2, 0, 1'b0);
    chk("t5_ovf_set", ov_v[3], 1);
    frame_end();
    drain("t5_ovf_drain");
    chk("t5_ovf_held", ov_v[3], 1);
    chk("t5_ovf_frame_done", fd_cnt[3], 1);

    // Reset mid-line: outputs clear at once; no capture until vsyn low then high
    for (int a = 0; a < 10; a++) push(0, a, 'hF0F);
    frame_begin(4'b0001);
    href = 1'b1;
    for (int a = 0; a < 10; a++) begin
      camera_data = 8'hF8;
      cyc();
      camera_data = 8'h1F;
      cyc();
    end
    camera_data = 8'hF8;
    cyc();
    chk("t6_pre_reset_writes", exp_q.size(), 0);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_wren", wren_v[0], 0);
    chk("t6_rst_color", col_v[0], 0);
    chk("t6_rst_addr", addr_v[0], 0);
    chk("t6_rst_busy", busy_v[0], 0);
    chk("t6_rst_addr_ovf", ov_v[3], 0);
    camera_data = 8'h1F;
    cyc();
    camera_data = 8'hF8;
    cyc();
    rst = 1'b1;
    send_line(20, 0, 0, 1'b0);
    chk("t6_busy_wait_sync", busy_v[0], 0);
    frame_end();
    chk("t6_no_frame_done", fd_cnt[0], 4);
    for (int a = 0; a < 4; a++) push(0, a, 'hF0F);
    frame_begin(4'b0001);
    chk("t6_busy_resumed", busy_v[0], 1);
    send_line(4, 0, 0, 1'b0);
    frame_end();
    drain("t6_drain");
    chk("t6_frame_done", fd_cnt[0], 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
